// File: rtl/seq_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : seq_ctrl_pkg
//  Purpose  : Shared encodings for the sequencer: major opcodes, long
//             sub-ops, ALU operations, PC modes and instruction classes.
//  Revision : 1.0  initial release
// ============================================================================
package seq_ctrl_pkg;

    // Major opcodes, carried in ir[7:5]. 3'b110 and 3'b111 are unassigned.
    localparam logic [2:0] cu_long_begin = 3'b000;
    localparam logic [2:0] cu_add        = 3'b001;
    localparam logic [2:0] cu_lda        = 3'b010;
    localparam logic [2:0] cu_sta        = 3'b011;
    localparam logic [2:0] cu_jmp        = 3'b100;
    localparam logic [2:0] cu_ban        = 3'b101;

    // Long sub-ops, carried in ir[4:0] when the major opcode is cu_long_begin.
    localparam logic [4:0] cu_cla  = 5'd1;
    localparam logic [4:0] cu_com  = 5'd2;
    localparam logic [4:0] cu_shr  = 5'd3;
    localparam logic [4:0] cu_csl  = 5'd4;
    localparam logic [4:0] cu_stop = 5'd5;

    // ALU operations presented alongside acc_we.
    localparam logic [3:0] alu_cla  = 4'd0;
    localparam logic [3:0] alu_add  = 4'd1;
    localparam logic [3:0] alu_pass = 4'd2;
    localparam logic [3:0] alu_com  = 4'd3;
    localparam logic [3:0] alu_shr  = 4'd4;
    localparam logic [3:0] alu_csl  = 4'd5;

    // Program-counter modes, one-hot.
    localparam logic [2:0] pc_mode_normal = 3'b001;
    localparam logic [2:0] pc_mode_jump   = 3'b010;
    localparam logic [2:0] pc_mode_stop   = 3'b100;

    // Instruction classes produced by the decoder; they select the FSM path.
    typedef enum logic [2:0] {
        cls_memrd   = 3'd0,
        cls_memwr   = 3'd1,
        cls_jmp     = 3'd2,
        cls_ban     = 3'd3,
        cls_long    = 3'd4,
        cls_stop    = 3'd5,
        cls_illegal = 3'd6
    } instr_cls_t;

endpackage
`default_nettype wire

// File: rtl/seq_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : seq_decode
//  Purpose  : Combinational instruction classifier. Maps the latched
//             instruction to an FSM class, an ALU operation and a flag
//             saying whether the instruction writes the accumulator.
//  Revision : 1.0  initial release
// ============================================================================
module seq_decode
    import seq_ctrl_pkg::*;
(
    input  logic [7:0] ir,
    output instr_cls_t cls,
    output logic [3:0] alu_op,
    output logic       acc_write
);

    // Classify on the major opcode, then on the long sub-op.
    always_comb begin
        cls       = cls_illegal;
        alu_op    = alu_cla;
        acc_write = 1'b0;
        case (ir[7:5])
            cu_add: begin
                cls       = cls_memrd;
                alu_op    = alu_add;
                acc_write = 1'b1;
            end
            cu_lda: begin
                cls       = cls_memrd;
                alu_op    = alu_pass;
                acc_write = 1'b1;
            end
            cu_sta: cls = cls_memwr;
            cu_jmp: cls = cls_jmp;
            cu_ban: cls = cls_ban;
            cu_long_begin: begin
                case (ir[4:0])
                    cu_cla: begin cls = cls_long; alu_op = alu_cla; acc_write = 1'b1; end
                    cu_com: begin cls = cls_long; alu_op = alu_com; acc_write = 1'b1; end
                    cu_shr: begin cls = cls_long; alu_op = alu_shr; acc_write = 1'b1; end
                    cu_csl: begin cls = cls_long; alu_op = alu_csl; acc_write = 1'b1; end
                    cu_stop: cls = cls_stop;
                    default: cls = cls_illegal;
                endcase
            end
            default: cls = cls_illegal;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : seq_ctrl
//  Purpose  : Instruction sequencer. Fetches an instruction, optionally
//             performs one memory read or write, pulses the accumulator
//             write and reports the PC mode once per instruction.
//  Revision : 1.0  initial release
// ============================================================================
module seq_ctrl
    import seq_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    input  logic       acc,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic [7:0] ir,
    output logic       acc_we,
    output logic [3:0] alu_op,
    output logic [2:0] pc,
    output logic       busy,
    output logic       halted,
    output logic       illegal
);

    typedef enum logic [2:0] {
        st_idle   = 3'd0,
        st_fetch  = 3'd1,
        st_decode = 3'd2,
        st_memrd  = 3'd3,
        st_memwr  = 3'd4,
        st_exec   = 3'd5,
        st_updpc  = 3'd6,
        st_halt   = 3'd7
    } state_t;

    state_t     r_state;
    logic [7:0] r_ir;
    logic       r_mem_req;
    logic       r_mem_we;
    logic       r_addr_sel;
    logic       r_acc_we;
    logic [3:0] r_alu_op;
    logic [2:0] r_pc;
    logic       r_ban;
    logic       r_busy;
    logic       r_halted;
    logic       r_illegal;

    instr_cls_t w_cls;
    logic [3:0] w_alu_op;
    logic       w_acc_write;
    logic [2:0] w_upd_pc;

    // The latched instruction stays stable for the whole instruction, so
    // its class is valid in every state after FETCH.
    seq_decode u_decode (
        .ir        (r_ir),
        .cls       (w_cls),
        .alu_op    (w_alu_op),
        .acc_write (w_acc_write)
    );

    // PC mode loaded on entry to UPDPC; ban is resolved later from live acc.
    assign w_upd_pc = (w_cls == cls_jmp)  ? pc_mode_jump :
                      (w_cls == cls_stop) ? pc_mode_stop : pc_mode_normal;

    // Sequencer FSM with registered outputs; acc_we and pc are one-cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= st_idle;
            r_ir       <= 8'd0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_addr_sel <= 1'b0;
            r_acc_we   <= 1'b0;
            r_alu_op   <= alu_cla;
            r_pc       <= pc_mode_normal;
            r_ban      <= 1'b0;
            r_busy     <= 1'b0;
            r_halted   <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_acc_we <= 1'b0;
            r_pc     <= pc_mode_normal;
            r_ban    <= 1'b0;
            case (r_state)
                st_idle: begin
                    if (start) begin
                        r_state    <= st_fetch;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_addr_sel <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                st_fetch: begin
                    if (mem_ack) begin
                        r_ir      <= mem_rdata;
                        r_mem_req <= 1'b0;
                        r_state   <= st_decode;
                    end
                end
                st_decode: begin
                    case (w_cls)
                        cls_memrd: begin
                            r_state    <= st_memrd;
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= 1'b0;
                            r_addr_sel <= 1'b1;
                        end
                        cls_memwr: begin
                            r_state    <= st_memwr;
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= 1'b1;
                            r_addr_sel <= 1'b1;
                        end
                        cls_long, cls_stop: begin
                            r_state  <= st_exec;
                            r_acc_we <= w_acc_write;
                            if (w_acc_write) begin
                                r_alu_op <= w_alu_op;
                            end
                        end
                        cls_jmp, cls_ban: begin
                            r_state <= st_updpc;
                            r_pc    <= w_upd_pc;
                            r_ban   <= (w_cls == cls_ban);
                        end
                        default: begin
                            r_illegal <= 1'b1;
                            r_state   <= st_updpc;
                        end
                    endcase
                end
                st_memrd: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= st_exec;
                        r_acc_we  <= w_acc_write;
                        r_alu_op  <= w_alu_op;
                    end
                end
                st_memwr: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= st_updpc;
                    end
                end
                st_exec: begin
                    r_state <= st_updpc;
                    r_pc    <= w_upd_pc;
                end
                st_updpc: begin
                    if (w_cls == cls_stop) begin
                        r_state  <= st_halt;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        r_state    <= st_fetch;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_addr_sel <= 1'b0;
                    end
                end
                st_halt: begin
                    r_state <= st_halt;
                end
                default: r_state <= st_idle;
            endcase
        end
    end

    assign mem_req  = r_mem_req;
    assign mem_we   = r_mem_we;
    assign addr_sel = r_addr_sel;
    assign ir       = r_ir;
    assign acc_we   = r_acc_we;
    assign alu_op   = r_alu_op;
    assign busy     = r_busy;
    assign halted   = r_halted;
    assign illegal  = r_illegal;
    // Branch-on-acc uses acc as seen during the UPDPC cycle itself.
    assign pc       = r_ban ? (acc ? pc_mode_jump : pc_mode_normal) : r_pc;

endmodule
`default_nettype wire
